// File: rtl/ac_rle_encoder.sv
// Run-length encoder for the 63 AC coefficients of one 8x8 block (zig-zag order).
// Emits {run, level} symbols with JPEG ZRL/EOB handling through a single-entry output register.
module ac_rle_encoder #(
  parameter int COEF_W = 10,
  parameter int RUN_W  = 4,
  parameter int CNT_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COEF_W-1:0]       in_coef,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RUN_W+COEF_W-1:0] out_sym
);

  localparam int SYM_W = RUN_W + COEF_W;
  localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(1 << RUN_W);
  localparam logic [SYM_W-1:0] ZRL_SYM = {{RUN_W{1'b1}}, {COEF_W{1'b0}}};

  typedef enum logic {S_ACC, S_ZRL} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_zcnt, w_zcnt_nxt;
  logic [COEF_W-1:0]  r_hold_coef;
  logic               r_out_valid;
  logic [SYM_W-1:0]   r_out_sym;
  logic               w_free, w_accept, w_load, w_hold_en;
  logic [SYM_W-1:0]   w_load_sym;

  assign w_free    = !r_out_valid || out_ready;
  assign in_ready  = (r_state == S_ACC) && w_free && reset;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_sym   = r_out_sym;

  always_comb begin
    w_state_nxt = r_state;
    w_zcnt_nxt  = r_zcnt;
    w_load      = 1'b0;
    w_load_sym  = '0;
    w_hold_en   = 1'b0;
    case (r_state)
      S_ACC: begin
        if (w_accept) begin
          if (in_coef == '0) begin
            if (in_last) begin
              w_load     = 1'b1;
              w_zcnt_nxt = '0;
            end else begin
              w_zcnt_nxt = r_zcnt + CNT_W'(1);
            end
          end else if (r_zcnt < RUN_LIM) begin
            w_load     = 1'b1;
            w_load_sym = {r_zcnt[RUN_W-1:0], in_coef};
            w_zcnt_nxt = '0;
          end else begin
            // First ZRL goes out on the accepting edge, so each ZRL costs exactly one input stall.
            w_load      = 1'b1;
            w_load_sym  = ZRL_SYM;
            w_zcnt_nxt  = r_zcnt - RUN_LIM;
            w_hold_en   = 1'b1;
            w_state_nxt = S_ZRL;
          end
        end
      end
      S_ZRL: begin
        if (w_free) begin
          w_load = 1'b1;
          if (r_zcnt >= RUN_LIM) begin
            w_load_sym = ZRL_SYM;
            w_zcnt_nxt = r_zcnt - RUN_LIM;
          end else begin
            w_load_sym  = {r_zcnt[RUN_W-1:0], r_hold_coef};
            w_zcnt_nxt  = '0;
            w_state_nxt = S_ACC;
          end
        end
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_ACC;
      r_zcnt      <= '0;
      r_hold_coef <= '0;
      r_out_valid <= 1'b0;
      r_out_sym   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_zcnt  <= w_zcnt_nxt;
      if (w_hold_en) r_hold_coef <= in_coef;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_sym   <= w_load_sym;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ac_rle_encoder.sv
// Bench for ac_rle_encoder: directed blocks plus random blocks with random valid/ready,
// checked against a per-block symbol list computed from the JPEG run/ZRL/EOB rules.
module tb_ac_rle_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_coef = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_sym;

  ac_rle_encoder #(.COEF_W(10), .RUN_W(4), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int          blk[63];
  int          nzrl[63];
  logic [13:0] expq[$];
  int          p = 63;
  int          rdy_pct = 100, vld_pct = 100;
  int          stall_from = -1, stall_to = -1;
  bit          force_stall = 0;
  bit          held = 0;
  logic [13:0] held_sym = '0;
  bit          watch = 0;
  int          exp_stall = 0, stall_seen = 0;
  bit          prev_last = 0;
  bit          chk_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the block, count zeros, emit ZRLs for every full 16 before a nonzero.
  function automatic void build_expect();
    int z = 0;
    logic [3:0] r;
    logic [9:0] l;
    for (int i = 0; i < 63; i++) begin
      nzrl[i] = 0;
      if (blk[i] == 0) begin
        if (i == 62) expq.push_back(14'h0000);
        else z++;
      end else begin
        nzrl[i] = z / 16;
        repeat (z / 16) expq.push_back(14'h3C00);
        r = 4'(z % 16);
        l = 10'(blk[i]);
        expq.push_back({r, l});
        z = 0;
      end
    end
  endfunction

  task automatic cycle(input int k);
    bit full;
    @(negedge clk);
    force_stall = (k >= stall_from) && (k < stall_to);
    full = (rdy_pct == 100) && (vld_pct == 100) && !force_stall;
    out_ready = force_stall ? 1'b0 : ($urandom_range(99) < rdy_pct);
    in_valid  = (p < 63) && ($urandom_range(99) < vld_pct);
    in_coef   = (p < 63) ? 10'(blk[p]) : '0;
    in_last   = (p == 62);
    #1;
    if (chk_lat && prev_last) chk("last_latency", out_valid, 1);
    if (held) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", out_sym, held_sym);
    end
    if (out_valid && !out_ready) chk("ready_when_full", in_ready, 0);
    if (out_valid && out_ready) begin
      if (expq.size() == 0) chk("extra_symbol", out_valid, 0);
      else chk("symbol", out_sym, expq.pop_front());
    end
    if (!full) watch = 0;
    if (watch) begin
      if (!in_ready) stall_seen++;
      else begin
        chk("zrl_stall", stall_seen, exp_stall);
        watch = 0;
      end
    end
    prev_last = 0;
    if (in_valid && in_ready) begin
      if (full) begin
        watch = 1;
        exp_stall = nzrl[p];
        stall_seen = 0;
      end
      prev_last = (p == 62);
      p++;
    end
    held = out_valid && !out_ready;
    held_sym = out_sym;
  endtask

  task automatic run_block();
    build_expect();
    p = 0;
    for (int k = 0; k < 2000 && (p < 63 || expq.size() > 0); k++) cycle(k);
    chk("block_consumed", p, 63);
    chk("queue_drained", expq.size(), 0);
    expq.delete();
    stall_from = -1;
    stall_to = -1;
    cycle(-1);
    chk("idle_after_block", out_valid, 0);
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 63; i++) blk[i] = 0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sym", out_sym, 0);
    chk("reset_in_ready", in_ready, 0);
    reset = 1'b1;

    // All zero -> single EOB one cycle after in_last.
    chk_lat = 1;
    clear_blk();
    run_block();

    // Coef1 = 5 -> 0005, 0000.
    clear_blk(); blk[0] = 5;
    run_block();

    // 20 zeros then -3 -> 3C00, 13FD, 0000; one stall cycle.
    clear_blk(); blk[20] = -3;
    run_block();

    // 62 zeros, last = 7 -> 3x 3C00, 3807; no EOB.
    clear_blk(); blk[62] = 7;
    run_block();

    // Downstream stall for 5 cycles mid-block.
    clear_blk();
    for (int i = 0; i < 63; i += 3) blk[i] = i + 1;
    stall_from = 10; stall_to = 15;
    run_block();

    // Reset while draining ZRLs.
    clear_blk(); blk[40] = 9;
    build_expect();
    p = 0;
    for (int k = 0; k < 200 && p < 41; k++) cycle(k);
    chk("zrl_reached", p, 41);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("zrl_reset_out_valid", out_valid, 0);
    chk("zrl_reset_in_ready", in_ready, 0);
    reset = 1'b1;
    expq.delete();
    watch = 0; held = 0; prev_last = 0; p = 63;
    clear_blk(); blk[15] = 1;
    run_block();
    clear_blk();
    run_block();

    // Random blocks under random handshake.
    chk_lat = 0;
    for (int b = 0; b < 24; b++) begin
      int dens;
      case ($urandom_range(2))
        0: rdy_pct = 100;
        1: rdy_pct = 70;
        default: rdy_pct = 40;
      endcase
      vld_pct = ($urandom_range(1) == 0) ? 100 : 60;
      dens = $urandom_range(2, 30);
      for (int i = 0; i < 63; i++) begin
        int v;
        if ($urandom_range(99) < dens) begin
          v = $urandom_range(1, 1023);
          blk[i] = (v >= 512) ? v - 1024 : v;
        end else begin
          blk[i] = 0;
        end
      end
      run_block();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
